// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, immediate-format, opcode and mux-select encodings for the multicycle control
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_JAL, S_BRANCH, S_LUI, S_TRAP
  } state_t;
  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100
  } imm_src_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEMDATA = 2'b01, RES_ALURESULT = 2'b10, RES_IMMEXT = 2'b11;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
endpackage

// File: rtl/ctrl_output_decode.sv
// ctrl_output_decode: combinational state-to-control-strobe table with mem_ready and branch gating
module ctrl_output_decode
  import ctrl_pkg::*;
(
  input  state_t      state,
  input  logic        mem_ready,
  input  logic        zero,
  input  logic        branch_ne,
  input  logic        is_store,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output imm_src_t    imm_src,
  output logic        reg_write
);
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    imm_src    = IMM_I;
    reg_write  = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = is_store ? IMM_S : IMM_I;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        imm_src   = IMM_J;
        pc_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        pc_write  = zero ^ branch_ne;
      end
      S_LUI: begin
        result_src = RES_IMMEXT;
        imm_src    = IMM_U;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle main FSM with illegal-opcode trap and retired-instruction counter
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output imm_src_t         imm_src,
  output logic             reg_write,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret,
  output logic             retire
);
  state_t state_q, state_d;
  logic illegal_q, illegal_d, retire_q, retire_d, retiring;
  logic [CNT_W-1:0] instret_q, instret_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB, S_ALUWB, S_BRANCH, S_LUI: state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL:         state_d = S_ALUWB;
      default:    state_d = S_TRAP;
    endcase
    retiring  = (state_q inside {S_MEMWB, S_ALUWB, S_BRANCH, S_LUI}) ||
                (state_q == S_MEMWRITE && mem_ready);
    retire_d  = retiring;
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retiring};
    illegal_d = illegal_q | (state_d == S_TRAP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retire_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retire_q  <= retire_d;
      instret_q <= instret_d;
    end
  end
  ctrl_output_decode u_dec (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .branch_ne  (funct3[0]),
    .is_store   (opcode[5]),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .reg_write  (reg_write)
  );
  assign illegal_instr = illegal_q;
  assign retire        = retire_q;
  assign instret       = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-script reference model with directed and randomized stimulus
module tb_multicycle_ctrl;
  localparam int CW = 4;
  localparam int SF = 0, SD = 1, SA = 2, SR = 3, SW = 4, SS = 5, SX = 6, SY = 7, SU = 8, SJ = 9, SB = 10, SL = 11, ST = 12;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [CW-1:0] instret;
  int q[$];
  logic [31:0] prog[$];
  logic [31:0] ir = '0;
  logic known = 1'b0, exp_ret = 1'b0;
  logic [CW-1:0] exp_cnt = '0;
  int checks = 0, errors = 0;
  logic [16:0] snap;
  logic snap_ret;
  logic [CW-1:0] snap_cnt;
  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .reg_write(reg_write), .illegal_instr(illegal_instr),
    .instret(instret), .retire(retire)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask
  function automatic logic [16:0] exp_out(int s, logic rdy, logic z, logic [31:0] i);
    case (s)
      SF: return {rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00};
      SD: return {4'b0000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b010, 2'b00};
      SA: return {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, (i[5] ? 3'b001 : 3'b000), 2'b00};
      SR: return {4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
      SW: return {4'b0000, 2'b01, 6'b0, 3'b000, 2'b10};
      SS: return {4'b0110, 2'b00, 6'b0, 3'b000, 2'b00};
      SX: return {4'b0000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
      SY: return {4'b0000, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000, 2'b00};
      SU: return {4'b0000, 2'b00, 6'b0, 3'b000, 2'b10};
      SJ: return {4'b1000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b100, 2'b00};
      SB: return {z ^ i[12], 3'b000, 2'b00, 2'b10, 2'b00, 2'b01, 3'b000, 2'b00};
      SL: return {4'b0000, 2'b11, 6'b0, 3'b011, 2'b10};
      default: return 17'h00001;
    endcase
  endfunction
  function automatic logic [31:0] gen();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 19);
    if (k < 3) r[6:0] = 7'h03;
    else if (k < 6) r[6:0] = 7'h23;
    else if (k < 9) r[6:0] = 7'h33;
    else if (k < 12) r[6:0] = 7'h13;
    else if (k < 14) r[6:0] = 7'h6f;
    else if (k < 17) begin r[6:0] = 7'h63; r[14:13] = 2'b00; end
    else if (k == 17) r[6:0] = 7'h63;
    else if (k == 18) r[6:0] = 7'h37;
    else r[6:0] = r[31] ? 7'h17 : 7'h7f;
    return r;
  endfunction
  task automatic load_script();
    q.delete();
    q.push_back(SD);
    case (ir[6:0])
      7'h03: begin q.push_back(SA); q.push_back(SR); q.push_back(SW); end
      7'h23: begin q.push_back(SA); q.push_back(SS); end
      7'h33: begin q.push_back(SX); q.push_back(SU); end
      7'h13: begin q.push_back(SY); q.push_back(SU); end
      7'h6f: begin q.push_back(SJ); q.push_back(SU); end
      7'h63: q.push_back(ir[14:13] == 2'b00 ? SB : ST);
      7'h37: q.push_back(SL);
      default: q.push_back(ST);
    endcase
  endtask
  task automatic cycle(input logic r, input logic rdy, input logic z);
    int h;
    logic rt;
    rst = r;
    mem_ready = rdy;
    zero = z;
    @(negedge clk);
    snap = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal_instr};
    snap_ret = retire;
    snap_cnt = instret;
    if (known) begin
      chk("outputs", 32'(snap), 32'(exp_out(q[0], rdy, z, ir)));
      chk("retire", 32'(snap_ret), 32'(exp_ret));
      chk("instret", 32'(snap_cnt), 32'(exp_cnt));
    end
    @(posedge clk);
    #1;
    if (r) begin
      known = 1'b1;
      q.delete();
      q.push_back(SF);
      exp_ret = 1'b0;
      exp_cnt = '0;
    end else if (known) begin
      h = q[0];
      rt = (h == SW || h == SU || h == SB || h == SL || (h == SS && rdy));
      exp_ret = rt;
      exp_cnt = exp_cnt + {{(CW-1){1'b0}}, rt};
      if (!(h == ST || ((h == SF || h == SR || h == SS) && !rdy))) begin
        void'(q.pop_front());
        if (h == SF) begin
          ir = (prog.size() != 0) ? prog.pop_front() : gen();
          load_script();
        end
        if (q.size() == 0) q.push_back(SF);
      end
    end
    opcode = ir[6:0];
    funct3 = ir[14:12];
  endtask
  task automatic run_br(input logic [31:0] i, input logic z, input logic exp_pcw);
    prog.push_back(i);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, z);
    chk("branch_pc_write", 32'(snap[16]), 32'(exp_pcw));
  endtask
  initial begin
    int mw, rtc, ilc, stc, trapc;
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("reset_result_src", 32'(snap[12:11]), 32'h2);
    chk("reset_instret", 32'(snap_cnt), 32'h0);
    prog.push_back(32'h00a02503);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    chk("lw_memadr_imm", 32'(snap[4:2]), 32'h0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    chk("lw_wb_reg_write", 32'(snap[1]), 32'h1);
    chk("lw_wb_result_src", 32'(snap[12:11]), 32'h1);
    prog.push_back(32'h00552223);
    cycle(1'b0, 1'b1, 1'b0);
    chk("lw_instret", 32'(snap_cnt), 32'h1);
    chk("lw_retire", 32'(snap_ret), 32'h1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("sw_memadr_imm", 32'(snap[4:2]), 32'h1);
    mw = 0;
    rtc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, i == 3, 1'b0);
      mw += int'(snap[14]);
      rtc += int'(snap_ret);
    end
    prog.push_back(32'h00208463);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      rtc += int'(snap_ret);
    end
    chk("sw_mem_write_cycles", mw, 4);
    chk("sw_retire_pulses", rtc, 1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("beq_taken", 32'(snap[16]), 32'h1);
    run_br(32'h00208463, 1'b0, 1'b0);
    run_br(32'h00209463, 1'b1, 1'b0);
    run_br(32'h00209463, 1'b0, 1'b1);
    prog.push_back(32'h12345537);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    chk("lui_result_src", 32'(snap[12:11]), 32'h3);
    chk("lui_imm_src", 32'(snap[4:2]), 32'h3);
    chk("lui_reg_write", 32'(snap[1]), 32'h1);
    prog.push_back(32'h0010006f);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    chk("jal_imm_src", 32'(snap[4:2]), 32'h4);
    chk("jal_pc_write", 32'(snap[16]), 32'h1);
    cycle(1'b0, 1'b1, 1'b0);
    chk("jal_aluwb_reg_write", 32'(snap[1]), 32'h1);
    prog.push_back(32'hfff10093);
    prog.push_back(32'h0000007f);
    repeat (6) cycle(1'b0, 1'b1, 1'b0);
    ilc = 0;
    stc = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ilc += int'(snap[0]);
      stc += int'(snap[16] | snap[14] | snap[13] | snap[1]);
    end
    chk("trap_instret", 32'(snap_cnt), 32'h9);
    chk("trap_illegal_cycles", ilc, 10);
    chk("trap_strobes", stc, 0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("post_rst_illegal", 32'(snap[0]), 32'h0);
    chk("post_rst_instret", 32'(snap_cnt), 32'h0);
    repeat (16) prog.push_back(32'h12345537);
    repeat (48) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("wrap_instret", 32'(snap_cnt), 32'h0);
    chk("wrap_retire", 32'(snap_ret), 32'h1);
    trapc = 0;
    for (int i = 0; i < 4000; i++) begin
      if (q[0] == ST) trapc++;
      if (trapc > 10 || $urandom_range(0, 299) == 0) begin
        cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        trapc = 0;
      end else begin
        cycle(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
